// File: rtl/tcm_mem.sv
// tcm_mem: tightly-coupled dual-port memory for the RV32 core.
// Port A is a read-only instruction fetch port. Port B is a load/store port
// with byte/half/word stores. Both ports accept one request per cycle with no
// stall and answer a fixed RD_LATENCY cycles later. An address outside the
// decode window, a misaligned access, an illegal size, or a store into a ROM
// instance is answered with err=1 and zero data, and nothing is written.
module tcm_mem #(
    parameter int unsigned MEM_DEPTH      = 4096,
    parameter int unsigned MEM_ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned RD_LATENCY     = 1,
    parameter bit          WRITABLE       = 1'b1,
    parameter string       INIT_FILE      = ""
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr_addr,
    input  logic        i_instr_req,
    output logic [31:0] o_instr_data,
    output logic        o_instr_ack,
    output logic        o_instr_err,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wr_data,
    input  logic [1:0]  i_data_size,
    input  logic        i_data_we,
    input  logic        i_data_req,
    output logic [31:0] o_data_rd_data,
    output logic        o_data_ack,
    output logic        o_data_err
);

    localparam logic [32:0] WIN_BYTES = 33'(MEM_DEPTH) << 2;

    if (MEM_DEPTH != (32'd1 << MEM_ADDR_WIDTH)) begin : g_chk_depth
        $error("tcm_mem: MEM_DEPTH must equal 2**MEM_ADDR_WIDTH");
    end
    if ((RD_LATENCY < 1) || (RD_LATENCY > 4)) begin : g_chk_lat
        $error("tcm_mem: RD_LATENCY must be in 1..4");
    end
    if ((BASE_ADDR % (4 * MEM_DEPTH)) != 0) begin : g_chk_base
        $error("tcm_mem: BASE_ADDR must be aligned to the window size");
    end

    logic [31:0] mem_q [MEM_DEPTH];

    logic [31:0]               f_off;
    logic [31:0]               d_off;
    logic [MEM_ADDR_WIDTH-1:0] f_idx;
    logic [MEM_ADDR_WIDTH-1:0] d_idx;
    logic                      f_fault;
    logic                      d_fault;
    logic                      d_size_bad;
    logic [3:0]                d_be;
    logic [31:0]               d_wdata;
    logic                      d_wr_en;

    // Address decode, fault classification and store lane steering.
    always_comb begin
        f_off      = i_instr_addr - BASE_ADDR;
        d_off      = i_data_addr - BASE_ADDR;
        f_idx      = f_off[MEM_ADDR_WIDTH+1:2];
        d_idx      = d_off[MEM_ADDR_WIDTH+1:2];
        f_fault    = ({1'b0, f_off} >= WIN_BYTES) || (i_instr_addr[1:0] != 2'b00);
        d_size_bad = 1'b0;
        d_be       = 4'b0000;
        d_wdata    = i_data_wr_data;
        case (i_data_size)
            2'd0: begin
                d_be    = 4'b0001 << i_data_addr[1:0];
                d_wdata = {4{i_data_wr_data[7:0]}};
            end
            2'd1: begin
                d_size_bad = i_data_addr[0];
                d_be       = 4'b0011 << {i_data_addr[1], 1'b0};
                d_wdata    = {2{i_data_wr_data[15:0]}};
            end
            2'd2: begin
                d_size_bad = |i_data_addr[1:0];
                d_be       = 4'b1111;
            end
            default: d_size_bad = 1'b1;
        endcase
        d_fault = ({1'b0, d_off} >= WIN_BYTES) || d_size_bad || (i_data_we && !WRITABLE);
        // A request during reset is ignored entirely, so it must not write.
        d_wr_en = i_data_req && i_data_we && !d_fault && !i_rst;
    end

    // A ROM instance has no write port at all.
    if (WRITABLE) begin : g_write
        // Byte-lane store committed at the accept edge.
        always_ff @(posedge i_clk) begin
            if (d_wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (d_be[b]) begin
                        mem_q[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    logic [RD_LATENCY-1:0] f_vld_q;
    logic [RD_LATENCY-1:0] f_err_q;
    logic [31:0]           f_data_q [RD_LATENCY];
    logic [RD_LATENCY-1:0] d_vld_q;
    logic [RD_LATENCY-1:0] d_err_q;
    logic [31:0]           d_data_q [RD_LATENCY];

    // Stage 0 samples the array at the accept edge (read-first against a
    // same-edge store); later stages only add delay. Reset drops everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            f_vld_q <= '0;
            f_err_q <= '0;
            d_vld_q <= '0;
            d_err_q <= '0;
            for (int s = 0; s < int'(RD_LATENCY); s++) begin
                f_data_q[s] <= '0;
                d_data_q[s] <= '0;
            end
        end else begin
            f_vld_q[0]  <= i_instr_req;
            f_err_q[0]  <= i_instr_req && f_fault;
            f_data_q[0] <= (i_instr_req && !f_fault) ? mem_q[f_idx] : '0;
            d_vld_q[0]  <= i_data_req;
            d_err_q[0]  <= i_data_req && d_fault;
            d_data_q[0] <= (i_data_req && !d_fault && !i_data_we) ? mem_q[d_idx] : '0;
            for (int s = 1; s < int'(RD_LATENCY); s++) begin
                f_vld_q[s]  <= f_vld_q[s-1];
                f_err_q[s]  <= f_err_q[s-1];
                f_data_q[s] <= f_data_q[s-1];
                d_vld_q[s]  <= d_vld_q[s-1];
                d_err_q[s]  <= d_err_q[s-1];
                d_data_q[s] <= d_data_q[s-1];
            end
        end
    end

    assign o_instr_ack    = f_vld_q[RD_LATENCY-1];
    assign o_instr_err    = f_err_q[RD_LATENCY-1];
    assign o_instr_data   = f_data_q[RD_LATENCY-1];
    assign o_data_ack     = d_vld_q[RD_LATENCY-1];
    assign o_data_err     = d_err_q[RD_LATENCY-1];
    assign o_data_rd_data = d_data_q[RD_LATENCY-1];

endmodule

// File: tb/tb_tcm_mem.sv
// Testbench for tcm_mem. There are three instances:
//   A: latency 3, writable, base 0. It gets directed and random traffic, and a
//      byte-addressed reference memory checks every cycle.
//   B: latency 4, writable, base 0x1000. It is used to check a reset that
//      arrives while requests are still in flight.
//   C: latency 1, ROM. Its image is preloaded into the array.
module tb_tcm_mem;
    localparam int          A_DEPTH = 256;
    localparam int          A_LAT   = 3;
    localparam int          B_LAT   = 4;
    localparam logic [31:0] B_BASE  = 32'h1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    logic [31:0] a_instr_addr, a_instr_data, a_data_addr, a_data_wr_data, a_data_rd_data;
    logic        a_instr_req, a_instr_ack, a_instr_err, a_data_we, a_data_req, a_data_ack, a_data_err;
    logic [1:0]  a_data_size;
    logic [31:0] b_instr_addr, b_instr_data, b_data_addr, b_data_wr_data, b_data_rd_data;
    logic        b_instr_req, b_instr_ack, b_instr_err, b_data_we, b_data_req, b_data_ack, b_data_err;
    logic [1:0]  b_data_size;
    logic [31:0] c_instr_addr, c_instr_data, c_data_addr, c_data_wr_data, c_data_rd_data;
    logic        c_instr_req, c_instr_ack, c_instr_err, c_data_we, c_data_req, c_data_ack, c_data_err;
    logic [1:0]  c_data_size;

    tcm_mem #(.MEM_DEPTH(A_DEPTH), .MEM_ADDR_WIDTH(8), .BASE_ADDR(32'h0),
              .RD_LATENCY(A_LAT), .WRITABLE(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst_a),
        .i_instr_addr(a_instr_addr), .i_instr_req(a_instr_req),
        .o_instr_data(a_instr_data), .o_instr_ack(a_instr_ack), .o_instr_err(a_instr_err),
        .i_data_addr(a_data_addr), .i_data_wr_data(a_data_wr_data), .i_data_size(a_data_size),
        .i_data_we(a_data_we), .i_data_req(a_data_req),
        .o_data_rd_data(a_data_rd_data), .o_data_ack(a_data_ack), .o_data_err(a_data_err));

    tcm_mem #(.MEM_DEPTH(256), .MEM_ADDR_WIDTH(8), .BASE_ADDR(B_BASE),
              .RD_LATENCY(B_LAT), .WRITABLE(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst_b),
        .i_instr_addr(b_instr_addr), .i_instr_req(b_instr_req),
        .o_instr_data(b_instr_data), .o_instr_ack(b_instr_ack), .o_instr_err(b_instr_err),
        .i_data_addr(b_data_addr), .i_data_wr_data(b_data_wr_data), .i_data_size(b_data_size),
        .i_data_we(b_data_we), .i_data_req(b_data_req),
        .o_data_rd_data(b_data_rd_data), .o_data_ack(b_data_ack), .o_data_err(b_data_err));

    tcm_mem #(.MEM_DEPTH(256), .MEM_ADDR_WIDTH(8), .BASE_ADDR(32'h0),
              .RD_LATENCY(1), .WRITABLE(1'b0)) dut_c (
        .i_clk(clk), .i_rst(rst_c),
        .i_instr_addr(c_instr_addr), .i_instr_req(c_instr_req),
        .o_instr_data(c_instr_data), .o_instr_ack(c_instr_ack), .o_instr_err(c_instr_err),
        .i_data_addr(c_data_addr), .i_data_wr_data(c_data_wr_data), .i_data_size(c_data_size),
        .i_data_we(c_data_we), .i_data_req(c_data_req),
        .o_data_rd_data(c_data_rd_data), .o_data_ack(c_data_ack), .o_data_err(c_data_err));

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t       qf[$];
    resp_t       qd[$];
    int          cyc_a = 0;
    logic [7:0]  mb [4*A_DEPTH];
    logic [31:0] a_last_f_data;
    logic [31:0] a_last_d_data;
    logic [31:0] c_img [16];

    // Reference model for instance A, kept as a plain little-endian byte array.
    function automatic logic [32:0] model_fetch(input logic [31:0] addr);
        if (addr >= 32'(4*A_DEPTH) || (addr % 4) != 0) return {1'b1, 32'h0};
        return {1'b0, mb[addr+3], mb[addr+2], mb[addr+1], mb[addr]};
    endfunction

    function automatic logic [32:0] model_data(input logic [31:0] addr, input logic [1:0] size,
                                               input logic we, input logic [31:0] wd);
        int          nbytes;
        logic [31:0] w;
        if (addr >= 32'(4*A_DEPTH)) return {1'b1, 32'h0};
        if (size == 2'd3) return {1'b1, 32'h0};
        nbytes = 1 << size;
        if ((addr % nbytes) != 0) return {1'b1, 32'h0};
        if (we) begin
            for (int i = 0; i < nbytes; i++) mb[addr+i] = wd[8*i +: 8];
            return {1'b1 ^ 1'b1, 32'h0};
        end
        w = addr - (addr % 4);
        return {1'b0, mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of instance A: drive, predict, clock, then check both ports.
    task automatic a_step(input logic freq, input logic [31:0] faddr, input logic dreq,
                          input logic [31:0] daddr, input logic [1:0] dsize,
                          input logic dwe, input logic [31:0] dwd);
        resp_t       r;
        logic [32:0] m;
        a_instr_req    = freq;
        a_instr_addr   = faddr;
        a_data_req     = dreq;
        a_data_addr    = daddr;
        a_data_size    = dsize;
        a_data_we      = dwe;
        a_data_wr_data = dwd;
        if (freq) begin
            m = model_fetch(faddr);
            r.due = cyc_a + A_LAT; r.err = m[32]; r.data = m[31:0];
            qf.push_back(r);
        end
        if (dreq) begin
            m = model_data(daddr, dsize, dwe, dwd);
            r.due = cyc_a + A_LAT; r.err = m[32]; r.data = m[31:0];
            qd.push_back(r);
        end
        tick();
        cyc_a++;
        a_instr_req = 1'b0;
        a_data_req  = 1'b0;
        vectors++;
        if (qf.size() > 0 && qf[0].due == cyc_a) begin
            if (a_instr_ack !== 1'b1 || a_instr_err !== qf[0].err || a_instr_data !== qf[0].data) begin
                miscompares++;
                $display("FAIL fetch_resp cyc=%0d got ack=%b err=%b data=%h want ack=1 err=%b data=%h",
                         cyc_a, a_instr_ack, a_instr_err, a_instr_data, qf[0].err, qf[0].data);
            end
            a_last_f_data = a_instr_data;
            void'(qf.pop_front());
        end else if (a_instr_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_spurious_ack cyc=%0d got ack=%b want 0", cyc_a, a_instr_ack);
        end
        vectors++;
        if (qd.size() > 0 && qd[0].due == cyc_a) begin
            if (a_data_ack !== 1'b1 || a_data_err !== qd[0].err || a_data_rd_data !== qd[0].data) begin
                miscompares++;
                $display("FAIL data_resp cyc=%0d got ack=%b err=%b data=%h want ack=1 err=%b data=%h",
                         cyc_a, a_data_ack, a_data_err, a_data_rd_data, qd[0].err, qd[0].data);
            end
            a_last_d_data = a_data_rd_data;
            void'(qd.pop_front());
        end else if (a_data_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL data_spurious_ack cyc=%0d got ack=%b want 0", cyc_a, a_data_ack);
        end
    endtask

    task automatic a_drain();
        for (int i = 0; i <= A_LAT; i++) a_step(1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        vectors++;
        if (qf.size() != 0 || qd.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout got pending fetch=%0d data=%0d want 0 0", qf.size(), qd.size());
            qf.delete();
            qd.delete();
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({a_instr_ack, a_instr_err, a_instr_data, a_data_ack, a_data_err, a_data_rd_data} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_a got ack=%b%b err=%b%b want all zero", a_instr_ack, a_data_ack, a_instr_err, a_data_err);
        end
        vectors++;
        if ({b_instr_ack, b_instr_err, b_instr_data, b_data_ack, b_data_err, b_data_rd_data} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_b got ack=%b%b err=%b%b want all zero", b_instr_ack, b_data_ack, b_instr_err, b_data_err);
        end
        vectors++;
        if ({c_instr_ack, c_instr_err, c_instr_data, c_data_ack, c_data_err, c_data_rd_data} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_c got ack=%b%b err=%b%b want all zero", c_instr_ack, c_data_ack, c_instr_err, c_data_err);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int w = 0; w < A_DEPTH; w++)
            a_step(1'b0, 32'h0, 1'b1, 32'(w*4), 2'd2, 1'b1, $urandom);
        a_drain();
    endtask

    task automatic test_fetch_latency();
        a_step(1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        a_step(1'b1, 32'h4, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        a_step(1'b1, 32'h8, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        a_drain();
    endtask

    task automatic test_byte_lanes();
        logic [31:0] junk;
        junk = $urandom;
        a_step(1'b0, 32'h0, 1'b1, 32'h10, 2'd2, 1'b1, 32'h11223344);
        a_step(1'b0, 32'h0, 1'b1, 32'h11, 2'd0, 1'b1, {junk[31:8], 8'hAA});
        a_step(1'b0, 32'h0, 1'b1, 32'h12, 2'd1, 1'b1, {junk[15:0], 16'hBEEF});
        a_step(1'b0, 32'h0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h0);
        a_drain();
        vectors++;
        if (a_last_d_data !== 32'hBEEFAA44) begin
            miscompares++;
            $display("FAIL byte_lanes got %h want beefaa44", a_last_d_data);
        end
    endtask

    task automatic test_faults();
        a_step(1'b1, 32'h2,   1'b1, 32'h3,   2'd1, 1'b0, 32'h0);
        a_step(1'b1, 32'h400, 1'b1, 32'h2,   2'd2, 1'b0, 32'h0);
        a_step(1'b0, 32'h0,   1'b1, 32'h0,   2'd3, 1'b0, 32'h0);
        a_step(1'b0, 32'h0,   1'b1, 32'h400, 2'd2, 1'b0, 32'h0);
        a_step(1'b0, 32'h0,   1'b1, 32'h6,   2'd2, 1'b1, 32'hCAFEF00D);
        a_step(1'b0, 32'h0,   1'b1, 32'h4,   2'd3, 1'b1, 32'hCAFEF00D);
        a_step(1'b0, 32'h0,   1'b1, 32'h404, 2'd2, 1'b1, 32'hCAFEF00D);
        a_step(1'b0, 32'h0,   1'b1, 32'h5,   2'd1, 1'b1, 32'hCAFEF00D);
        a_step(1'b1, 32'h4,   1'b1, 32'h0,   2'd2, 1'b0, 32'h0);
        a_step(1'b0, 32'h0,   1'b1, 32'h4,   2'd2, 1'b0, 32'h0);
        a_drain();
    endtask

    task automatic test_collision();
        a_step(1'b0, 32'h0,  1'b1, 32'h40, 2'd2, 1'b1, 32'h1);
        a_drain();
        a_step(1'b1, 32'h40, 1'b1, 32'h40, 2'd2, 1'b1, 32'h2);
        a_drain();
        vectors++;
        if (a_last_f_data !== 32'h1) begin
            miscompares++;
            $display("FAIL collision_read_first got %h want 00000001", a_last_f_data);
        end
        a_step(1'b1, 32'h40, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        a_drain();
        vectors++;
        if (a_last_f_data !== 32'h2) begin
            miscompares++;
            $display("FAIL collision_after got %h want 00000002", a_last_f_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] fa, da;
        for (int n = 0; n < 600; n++) begin
            fa = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) fa = fa & ~32'h3;
            da = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            a_step(1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 3) != 0), da,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
        end
        a_drain();
    endtask

    task automatic test_rom();
        c_data_req = 1'b1; c_data_we = 1'b1; c_data_size = 2'd2;
        c_data_addr = 32'h20; c_data_wr_data = 32'hDEADBEEF;
        tick();
        c_data_req = 1'b0;
        vectors++;
        if (c_data_ack !== 1'b1 || c_data_err !== 1'b1 || c_data_rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rom_store got ack=%b err=%b data=%h want ack=1 err=1 data=0",
                     c_data_ack, c_data_err, c_data_rd_data);
        end
        c_data_req = 1'b1; c_data_we = 1'b0;
        tick();
        c_data_req = 1'b0;
        vectors++;
        if (c_data_ack !== 1'b1 || c_data_err !== 1'b0 || c_data_rd_data !== c_img[8]) begin
            miscompares++;
            $display("FAIL rom_load got ack=%b err=%b data=%h want ack=1 err=0 data=%h",
                     c_data_ack, c_data_err, c_data_rd_data, c_img[8]);
        end
        c_data_req = 1'b1; c_data_we = 1'b1; c_data_size = 2'd0; c_data_addr = 32'h25;
        c_instr_req = 1'b1; c_instr_addr = 32'h24;
        tick();
        c_data_req = 1'b0; c_instr_req = 1'b0;
        vectors++;
        if (c_data_ack !== 1'b1 || c_data_err !== 1'b1 || c_instr_ack !== 1'b1 ||
            c_instr_err !== 1'b0 || c_instr_data !== c_img[9]) begin
            miscompares++;
            $display("FAIL rom_byte_fetch got dack=%b derr=%b fack=%b ferr=%b fdata=%h want 1 1 1 0 %h",
                     c_data_ack, c_data_err, c_instr_ack, c_instr_err, c_instr_data, c_img[9]);
        end
    endtask

    task automatic test_reset_flight();
        logic [31:0] v;
        int          got;
        v = $urandom;
        b_data_req = 1'b1; b_data_we = 1'b1; b_data_size = 2'd2;
        b_data_addr = B_BASE; b_data_wr_data = v;
        tick();
        b_data_req = 1'b0;
        repeat (6) tick();
        b_data_req = 1'b1; b_data_we = 1'b0;
        tick();
        b_data_addr = B_BASE + 32'h4;
        tick();
        rst_b = 1'b1; b_data_we = 1'b1; b_data_addr = B_BASE; b_data_wr_data = ~v;
        tick();
        rst_b = 1'b0; b_data_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (b_data_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_drop k=%0d got ack=%b want 0", k, b_data_ack);
            end
            tick();
        end
        got = 0;
        b_data_req = 1'b1; b_data_we = 1'b0; b_data_addr = B_BASE;
        for (int k = 1; k <= 10; k++) begin
            tick();
            b_data_req = 1'b0;
            if (b_data_ack === 1'b1) begin
                got = k;
                break;
            end
        end
        vectors++;
        if (got != B_LAT) begin
            miscompares++;
            $display("FAIL reset_recover_latency got %0d want %0d (0 = no ack in 10 cycles)", got, B_LAT);
        end
        vectors++;
        if (b_data_rd_data !== v || b_data_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_recover_data got err=%b data=%h want err=0 data=%h", b_data_err, b_data_rd_data, v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {a_instr_addr, a_instr_req, a_data_addr, a_data_wr_data, a_data_size, a_data_we, a_data_req} = '0;
        {b_instr_addr, b_instr_req, b_data_addr, b_data_wr_data, b_data_size, b_data_we, b_data_req} = '0;
        {c_instr_addr, c_instr_req, c_data_addr, c_data_wr_data, c_data_size, c_data_we, c_data_req} = '0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int i = 0; i < 16; i++) begin
            c_img[i] = $urandom;
            dut_c.mem_q[i] = c_img[i];
        end
        test_reset();
        test_fill();
        test_fetch_latency();
        test_byte_lanes();
        test_faults();
        test_collision();
        test_random();
        test_rom();
        test_reset_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
